// File: rtl/ul_frame_transmitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fec_pkg
//  Brief    : Shared types and constants for the uplink frame transmitter:
//             FSM state encoding, packet sizes, preamble length and the
//             saturating message-byte counter update.
//  Revision : 1.0 - initial release
// ============================================================================
package fec_pkg;

    localparam int DL_PREAMBLE_COUNT   = 8;
    localparam int UL_ID_PKT_BITS      = 24;
    localparam int UL_DATA_PKT_BITS    = 80;
    localparam int UL_BYTES_PER_FRAME  = 7;
    localparam int UL_SERIAL_DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PREAMBLE   = 3'd1,
        S_ID_SHIFT   = 3'd2,
        S_DATA_WAIT  = 3'd3,
        S_DATA_SHIFT = 3'd4,
        S_DONE       = 3'd5
    } ul_tx_state_t;

    // Byte count after one more data frame, saturating at the message length.
    // The sum is formed 9 bits wide so lengths near 255 cannot wrap.
    function automatic logic [7:0] ul_next_msg_cnt(input logic [7:0] cnt,
                                                   input logic [7:0] len);
        logic [8:0] sum;
        sum = {1'b0, cnt} + 9'(UL_BYTES_PER_FRAME);
        return (sum > {1'b0, len}) ? len : sum[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ul_frame_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ul_frame_transmitter_if
//  Brief    : Message request, data-packet handshake and serial line bundle
//             between the encoder side (master) and the transmitter (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface ul_frame_transmitter_if
    import fec_pkg::*;
#(
    parameter int SERIAL_DIV_WIDTH = UL_SERIAL_DIV_WIDTH,
    parameter int ID_PKT_BITS      = UL_ID_PKT_BITS,
    parameter int DATA_PKT_BITS    = UL_DATA_PKT_BITS
) ();

    logic                        start;
    logic [SERIAL_DIV_WIDTH-1:0] clk_div;
    logic [7:0]                  msg_len;
    logic [ID_PKT_BITS-1:0]      id_pkt;
    logic [DATA_PKT_BITS-1:0]    data_pkt;
    logic                        data_valid;
    logic                        data_ready;
    logic                        ul_out;
    logic                        ul_en;
    logic                        busy;
    logic                        done;
    logic [7:0]                  msg_cnt;

    modport master (
        output start, clk_div, msg_len, id_pkt, data_pkt, data_valid,
        input  data_ready, ul_out, ul_en, busy, done, msg_cnt
    );

    modport slave (
        input  start, clk_div, msg_len, id_pkt, data_pkt, data_valid,
        output data_ready, ul_out, ul_en, busy, done, msg_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ul_frame_transmitter_bit_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : ul_bit_shifter
//  Brief    : Parallel-load MSB-first serializer with programmable bit period.
//             A load starts a new burst of nbits bits on the following cycle;
//             last_bit flags the final cycle of the final bit so the caller
//             can chain the next load without a gap.
//  Revision : 1.0 - initial release
// ============================================================================
module ul_bit_shifter #(
    parameter int WIDTH     = 80,
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 load,
    input  wire logic [WIDTH-1:0]     load_data,
    input  wire logic [CNT_WIDTH-1:0] nbits,
    input  wire logic [DIV_WIDTH-1:0] clk_div,
    output logic                      bit_out,
    output logic                      bit_en,
    output logic                      last_bit
);

    logic [WIDTH-1:0]     sr_q,       sr_d;
    logic [DIV_WIDTH-1:0] div_cnt_q,  div_cnt_d;
    logic [CNT_WIDTH-1:0] bits_left_q, bits_left_d;
    logic                 active_q,   active_d;
    logic                 w_period_end;

    assign w_period_end = (div_cnt_q == clk_div);
    assign last_bit     = active_q && w_period_end && (bits_left_q == '0);
    assign bit_en       = active_q;
    assign bit_out      = active_q & sr_q[WIDTH-1];

    // Shifter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            div_cnt_q   <= '0;
            bits_left_q <= '0;
            active_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            div_cnt_q   <= div_cnt_d;
            bits_left_q <= bits_left_d;
            active_q    <= active_d;
        end
    end

    // Load, hold each bit clk_div+1 cycles, then shift; stop after the last bit
    always_comb begin
        sr_d        = sr_q;
        div_cnt_d   = div_cnt_q;
        bits_left_d = bits_left_q;
        active_d    = active_q;
        if (load) begin
            sr_d        = load_data;
            div_cnt_d   = '0;
            bits_left_d = nbits - 1'b1;
            active_d    = 1'b1;
        end else if (active_q) begin
            if (w_period_end) begin
                div_cnt_d = '0;
                sr_d      = {sr_q[WIDTH-2:0], 1'b0};
                if (bits_left_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    bits_left_d = bits_left_q - 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ul_frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : ul_frame_transmitter
//  Brief    : Uplink message framer. Sends preamble + ID packet, then one
//             preamble + data packet frame per 7 message bytes, serialized
//             MSB first at a programmable bit period.
//  Revision : 1.0 - initial release
// ============================================================================
module ul_frame_transmitter
    import fec_pkg::*;
#(
    parameter int SERIAL_DIV_WIDTH = UL_SERIAL_DIV_WIDTH,
    parameter int PREAMBLE_COUNT   = DL_PREAMBLE_COUNT,
    parameter int ID_PKT_BITS      = UL_ID_PKT_BITS,
    parameter int DATA_PKT_BITS    = UL_DATA_PKT_BITS
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ul_frame_transmitter_if.slave  bus
);

    localparam int CNT_WIDTH = $clog2(DATA_PKT_BITS + 1);

    // Alternating 1,0,1,0... training pattern, MSB-aligned in the shifter.
    function automatic logic [DATA_PKT_BITS-1:0] preamble_pattern();
        logic [DATA_PKT_BITS-1:0] p;
        p = '0;
        for (int i = 0; i < PREAMBLE_COUNT; i++) begin
            p[DATA_PKT_BITS-1-i] = ~i[0];
        end
        return p;
    endfunction

    localparam logic [DATA_PKT_BITS-1:0] PREAMBLE_PAT = preamble_pattern();

    ul_tx_state_t                state_q,      state_d;
    logic                        frame_data_q, frame_data_d;
    logic [SERIAL_DIV_WIDTH-1:0] clk_div_q,    clk_div_d;
    logic [7:0]                  msg_len_q,    msg_len_d;
    logic [7:0]                  msg_cnt_q,    msg_cnt_d;
    logic [ID_PKT_BITS-1:0]      id_pkt_q,     id_pkt_d;
    logic [DATA_PKT_BITS-1:0]    data_pkt_q,   data_pkt_d;

    logic                        sh_load;
    logic [DATA_PKT_BITS-1:0]    sh_data;
    logic [CNT_WIDTH-1:0]        sh_nbits;
    logic                        sh_last_bit;
    logic                        data_ready;
    logic                        busy;
    logic                        done;

    ul_bit_shifter #(
        .WIDTH     (DATA_PKT_BITS),
        .DIV_WIDTH (SERIAL_DIV_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_data),
        .nbits     (sh_nbits),
        .clk_div   (clk_div_q),
        .bit_out   (bus.ul_out),
        .bit_en    (bus.ul_en),
        .last_bit  (sh_last_bit)
    );

    assign bus.data_ready = data_ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.msg_cnt    = msg_cnt_q;

    // State and message-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_data_q <= 1'b0;
            clk_div_q    <= '0;
            msg_len_q    <= '0;
            msg_cnt_q    <= '0;
            id_pkt_q     <= '0;
            data_pkt_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_data_q <= frame_data_d;
            clk_div_q    <= clk_div_d;
            msg_len_q    <= msg_len_d;
            msg_cnt_q    <= msg_cnt_d;
            id_pkt_q     <= id_pkt_d;
            data_pkt_q   <= data_pkt_d;
        end
    end

    // Next-state and context updates: frame sequencing and byte counting
    always_comb begin
        state_d      = state_q;
        frame_data_d = frame_data_q;
        clk_div_d    = clk_div_q;
        msg_len_d    = msg_len_q;
        msg_cnt_d    = msg_cnt_q;
        id_pkt_d     = id_pkt_q;
        data_pkt_d   = data_pkt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    clk_div_d    = bus.clk_div;
                    msg_len_d    = bus.msg_len;
                    id_pkt_d     = bus.id_pkt;
                    msg_cnt_d    = '0;
                    frame_data_d = 1'b0;
                    state_d      = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (sh_last_bit) begin
                    state_d = frame_data_q ? S_DATA_SHIFT : S_ID_SHIFT;
                end
            end
            S_ID_SHIFT: begin
                if (sh_last_bit) begin
                    state_d = (msg_len_q == 8'd0) ? S_DONE : S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                if (bus.data_valid) begin
                    data_pkt_d   = bus.data_pkt;
                    msg_cnt_d    = ul_next_msg_cnt(msg_cnt_q, msg_len_q);
                    frame_data_d = 1'b1;
                    state_d      = S_PREAMBLE;
                end
            end
            S_DATA_SHIFT: begin
                if (sh_last_bit) begin
                    state_d = (msg_cnt_q >= msg_len_q) ? S_DONE : S_DATA_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and shifter loads; loads coincide with transitions so frames
    // start the cycle after the triggering edge and packets follow gaplessly
    always_comb begin
        data_ready = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        sh_load    = 1'b0;
        sh_data    = PREAMBLE_PAT;
        sh_nbits   = CNT_WIDTH'(PREAMBLE_COUNT);
        case (state_q)
            S_IDLE: begin
                sh_load = bus.start;
            end
            S_PREAMBLE: begin
                if (sh_last_bit) begin
                    sh_load = 1'b1;
                    if (frame_data_q) begin
                        sh_data  = data_pkt_q;
                        sh_nbits = CNT_WIDTH'(DATA_PKT_BITS);
                    end else begin
                        sh_data  = {id_pkt_q, {(DATA_PKT_BITS-ID_PKT_BITS){1'b0}}};
                        sh_nbits = CNT_WIDTH'(ID_PKT_BITS);
                    end
                end
            end
            S_DATA_WAIT: begin
                data_ready = 1'b1;
                sh_load    = bus.data_valid;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ul_frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ul_frame_transmitter
//  Brief    : Scoreboard bench for ul_frame_transmitter. Expected line bits
//             are queued when a message or data packet is issued and popped
//             on every ul_en cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ul_frame_transmitter;

    logic clk;
    logic rst;

    ul_frame_transmitter_if bus_if ();

    ul_frame_transmitter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_errors;
    int   en_cnt;
    int   dr_rises;
    logic dr_prev;
    logic mon_bit;
    logic exp_bits[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: every enabled cycle consumes one expected bit
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.ul_en) begin
                en_cnt++;
                if (exp_bits.size() == 0) begin
                    check("ul_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    mon_bit = exp_bits.pop_front();
                    check("ul_out_bit", {31'd0, bus_if.ul_out}, {31'd0, mon_bit});
                end
            end else begin
                check("ul_out_idle", {31'd0, bus_if.ul_out}, 32'd0);
            end
            if (bus_if.data_ready && !dr_prev) dr_rises++;
            dr_prev = bus_if.data_ready;
        end
    end

    task automatic push_frame(input logic [79:0] pkt, input int nbits, input int div);
        for (int i = 0; i < 8; i++)
            for (int r = 0; r <= div; r++) exp_bits.push_back((i % 2) == 0);
        for (int i = 0; i < nbits; i++)
            for (int r = 0; r <= div; r++) exp_bits.push_back(pkt[79-i]);
    endtask

    task automatic start_msg(input logic [7:0] len, input logic [7:0] div, input logic [23:0] id);
        push_frame({id, 56'd0}, 24, int'(div));
        en_cnt           = 0;
        dr_rises         = 0;
        bus_if.msg_len   = len;
        bus_if.clk_div   = div;
        bus_if.id_pkt    = id;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
        check("ul_en_after_start", {31'd0, bus_if.ul_en}, 32'd1);
    endtask

    task automatic send_data(input logic [79:0] pkt, input int div,
                             input logic [7:0] exp_cnt, input int hold);
        int k;
        int viol;
        k = 0;
        while (!bus_if.data_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("data_ready_seen", {31'd0, bus_if.data_ready}, 32'd1);
        viol = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus_if.data_ready || bus_if.ul_en) viol++;
            bus_if.start  = (h == 3);
            bus_if.id_pkt = 24'h0F0F0F;
        end
        bus_if.start = 1'b0;
        if (hold > 0) check("wait_hold_violations", viol, 0);
        push_frame(pkt, 80, div);
        bus_if.data_pkt   = pkt;
        bus_if.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.data_valid = 1'b0;
        bus_if.data_pkt   = {$urandom, $urandom, 16'hFFFF};
        check("msg_cnt_after_accept", {24'd0, bus_if.msg_cnt}, {24'd0, exp_cnt});
        check("preamble_after_accept", {31'd0, bus_if.ul_en}, 32'd1);
    endtask

    task automatic wait_done(input int exp_k);
        int k;
        k = 0;
        while (k < 5000) begin
            @(negedge clk);
            k++;
            if (bus_if.done) break;
        end
        check("done_cycle", k, exp_k);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
        check("busy_after_done", {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ul_out", {31'd0, bus_if.ul_out}, 32'd0);
        check("rst_ul_en", {31'd0, bus_if.ul_en}, 32'd0);
        check("rst_data_ready", {31'd0, bus_if.data_ready}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_msg_cnt", {24'd0, bus_if.msg_cnt}, 32'd0);
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        en_cnt            = 0;
        dr_rises          = 0;
        dr_prev           = 1'b0;
        rst               = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.clk_div    = '0;
        bus_if.msg_len    = '0;
        bus_if.id_pkt     = '0;
        bus_if.data_pkt   = '0;
        bus_if.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // ID-only message at full rate
        start_msg(8'd0, 8'd0, 24'hA5C3F0);
        wait_done(33);
        check("id_only_en_cycles", en_cnt, 32);
        check("id_only_ready_rises", dr_rises, 0);

        // One data frame; a stray data_valid during the ID frame is ignored
        start_msg(8'd7, 8'd0, 24'h123456);
        repeat (5) @(negedge clk);
        bus_if.data_pkt   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        bus_if.data_valid = 1'b1;
        @(negedge clk);
        bus_if.data_valid = 1'b0;
        send_data(80'hDEAD_BEEF_0123_4567_89AB, 0, 8'd7, 0);
        wait_done(89);
        check("len7_en_cycles", en_cnt, 120);
        check("len7_ready_rises", dr_rises, 1);

        // Two data frames, second one saturates the byte count
        start_msg(8'd8, 8'd0, 24'hC0FFEE);
        send_data(80'h0F1E_2D3C_4B5A_6978_8796, 0, 8'd7, 0);
        send_data(80'hA5A5_5A5A_F00F_0FF0_3CC3, 0, 8'd8, 0);
        wait_done(89);
        check("len8_en_cycles", en_cnt, 208);
        check("len8_ready_rises", dr_rises, 2);

        // Divided bit rate, ID only
        start_msg(8'd0, 8'd3, 24'h5A0FF1);
        wait_done(129);
        check("div3_en_cycles", en_cnt, 128);

        // Inputs changed mid-message must not take effect
        start_msg(8'd5, 8'd3, 24'h9E3779);
        bus_if.clk_div = 8'd0;
        bus_if.msg_len = 8'd200;
        bus_if.id_pkt  = 24'h000000;
        send_data(80'h1357_9BDF_2468_ACE0_1122, 3, 8'd5, 0);
        wait_done(353);
        check("div3_len5_en_cycles", en_cnt, 32 * 4 + 88 * 4);

        // Withheld data_valid with a start pulse while busy
        start_msg(8'd7, 8'd1, 24'hB16B00);
        send_data(80'hFEDC_BA98_7654_3210_0F0F, 1, 8'd7, 20);
        wait_done(177);
        check("hold_en_cycles", en_cnt, 32 * 2 + 88 * 2);
        check("hold_ready_rises", dr_rises, 1);

        // Reset in the middle of a data frame, then a clean restart
        start_msg(8'd14, 8'd0, 24'h3C3C3C);
        send_data(80'hCAFE_BABE_D00D_FACE_1234, 0, 8'd7, 0);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        exp_bits.delete();
        rst     = 1'b0;
        dr_prev = 1'b0;
        @(negedge clk);
        start_msg(8'd0, 8'd0, 24'h8BADF0);
        wait_done(33);
        check("restart_en_cycles", en_cnt, 32);

        check("scoreboard_drained", exp_bits.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
